// File: rtl/sdram_cmd_pkg.sv
// Shared definitions for the SDRAM bank/row agent.
// - Command codes of the 3-bit cmd field (upstream and downstream).
// - Bank count and field offsets of the 40-bit user command and 21-bit SDRAM command.
// - FSM state type and small command-class helpers.
package sdram_cmd_pkg;

  localparam logic [2:0] CmdLoadMode    = 3'd0;
  localparam logic [2:0] CmdAutoRefresh = 3'd1;
  localparam logic [2:0] CmdStopBurst   = 3'd2;
  localparam logic [2:0] CmdActive      = 3'd3;
  localparam logic [2:0] CmdPrecharge   = 3'd4;
  localparam logic [2:0] CmdWt          = 3'd5;
  localparam logic [2:0] CmdRd          = 3'd6;
  localparam logic [2:0] CmdNop         = 3'd7;

  localparam int unsigned NumBanks = 4;

  // 40-bit user command: {rsv(3), ba(2), row(16), A15-0(16), cmd(3)}
  localparam int unsigned UsrCmdLsb  = 0;
  localparam int unsigned UsrAddrLsb = 3;
  localparam int unsigned UsrRowLsb  = 19;
  localparam int unsigned UsrBaLsb   = 35;

  // 21-bit SDRAM command: {ba(2), A15-0(16), cmd(3)}
  localparam int unsigned OutCmdLsb  = 0;
  localparam int unsigned OutAddrLsb = 3;
  localparam int unsigned OutBaLsb   = 19;

  // A10 selects precharge-all
  localparam int unsigned A10Bit = 10;

  typedef enum logic [1:0] {StIdle, StPre, StAct, StIssue} agent_state_e;

  function automatic logic is_rw(input logic [2:0] cmd);
    return (cmd == CmdRd) || (cmd == CmdWt);
  endfunction

  // Commands that need every bank closed first
  function automatic logic is_all_bank(input logic [2:0] cmd);
    return (cmd == CmdAutoRefresh) || (cmd == CmdLoadMode);
  endfunction

endpackage

// File: rtl/sdram_open_row_table.sv
// Per-bank open-row table.
// - lk_*     : combinational lookup of one bank (open flag, row hit) plus any-bank-open.
// - set_*    : mark a bank open with a row.
// - clr_*    : close one bank, or all banks with clr_all_i.
// A set and a clear in the same cycle resolve in favour of the set.
module sdram_open_row_table
  import sdram_cmd_pkg::*;
#(
  parameter int unsigned RowWidth = 13
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          lk_ba_i,
  input  logic [RowWidth-1:0] lk_row_i,
  output logic                lk_open_o,
  output logic                lk_hit_o,
  output logic                any_open_o,
  input  logic                set_i,
  input  logic [1:0]          set_ba_i,
  input  logic [RowWidth-1:0] set_row_i,
  input  logic                clr_i,
  input  logic [1:0]          clr_ba_i,
  input  logic                clr_all_i
);

  logic [NumBanks-1:0]               open_q, open_d;
  logic [NumBanks-1:0][RowWidth-1:0] row_q, row_d;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    if (clr_all_i) begin
      open_d = '0;
    end else if (clr_i) begin
      open_d[clr_ba_i] = 1'b0;
    end
    if (set_i) begin
      open_d[set_ba_i] = 1'b1;
      row_d[set_ba_i]  = set_row_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q <= '0;
      row_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  assign lk_open_o  = open_q[lk_ba_i];
  assign lk_hit_o   = open_q[lk_ba_i] && (row_q[lk_ba_i] == lk_row_i);
  assign any_open_o = |open_q;

endmodule

// File: rtl/sdram_bank_row_agent.sv
// SDRAM bank/row agent: expands upstream user commands into the minimal
// PRECHARGE / ACTIVE / command sequence using a per-bank open-row table.
// Ports:
// - clk, rst_n              : clock, asynchronous active-low reset
// - s_axis_usr_cmd_*        : upstream command {rsv,ba,row,A,cmd} + user {stop,len-1}
// - m_axis_sdram_cmd_*      : downstream command {ba,A,cmd} + user (RD/WT only)
// Each emitted command is preceded by one cycle with valid low, so the output
// register is loaded on state entry and held until the handshake.
module sdram_bank_row_agent
  import sdram_cmd_pkg::*;
#(
  parameter int unsigned ROW_ADDR_WIDTH   = 13,
  parameter string       EN_EXPL_CMD_PASS = "true"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] s_axis_usr_cmd_data,
  input  logic [16:0] s_axis_usr_cmd_user,
  input  logic        s_axis_usr_cmd_valid,
  output logic        s_axis_usr_cmd_ready,
  output logic [20:0] m_axis_sdram_cmd_data,
  output logic [16:0] m_axis_sdram_cmd_user,
  output logic        m_axis_sdram_cmd_valid,
  input  logic        m_axis_sdram_cmd_ready
);

  localparam bit ExplPass = (EN_EXPL_CMD_PASS == "true");

  agent_state_e              state_q, state_d;
  logic [2:0]                cmd_q, cmd_d;
  logic [1:0]                ba_q, ba_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [15:0]               addr_q, addr_d;
  logic [16:0]               user_q, user_d;
  logic                      m_valid_q, m_valid_d;
  logic [20:0]               m_data_q, m_data_d;
  logic [16:0]               m_user_q, m_user_d;

  logic [2:0]                s_cmd;
  logic [1:0]                s_ba;
  logic [ROW_ADDR_WIDTH-1:0] s_row;
  logic [15:0]               s_addr;
  logic                      lk_open, lk_hit, any_open;
  logic                      tbl_set, tbl_clr, tbl_clr_all;
  logic                      m_hs;
  logic [20:0]               out_data;
  logic [16:0]               out_user;
  logic                      unused_data;

  assign s_cmd  = s_axis_usr_cmd_data[UsrCmdLsb +: 3];
  assign s_ba   = s_axis_usr_cmd_data[UsrBaLsb +: 2];
  assign s_row  = s_axis_usr_cmd_data[UsrRowLsb +: ROW_ADDR_WIDTH];
  assign s_addr = s_axis_usr_cmd_data[UsrAddrLsb +: 16];
  // rsv and row bits above ROW_ADDR_WIDTH are intentionally ignored
  assign unused_data = ^s_axis_usr_cmd_data;

  assign m_hs = m_valid_q && m_axis_sdram_cmd_ready;

  sdram_open_row_table #(
    .RowWidth (ROW_ADDR_WIDTH)
  ) u_table (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .lk_ba_i    (s_ba),
    .lk_row_i   (s_row),
    .lk_open_o  (lk_open),
    .lk_hit_o   (lk_hit),
    .any_open_o (any_open),
    .set_i      (tbl_set),
    .set_ba_i   (ba_q),
    .set_row_i  (row_q),
    .clr_i      (tbl_clr),
    .clr_ba_i   (ba_q),
    .clr_all_i  (tbl_clr_all)
  );

  // Table updates happen only on the downstream handshake of the emitted command
  always_comb begin
    tbl_set     = 1'b0;
    tbl_clr     = 1'b0;
    tbl_clr_all = 1'b0;
    if (m_hs) begin
      unique case (state_q)
        StPre: begin
          if (is_all_bank(cmd_q)) tbl_clr_all = 1'b1;
          else                    tbl_clr     = 1'b1;
        end
        StAct: tbl_set = 1'b1;
        StIssue: begin
          if (cmd_q == CmdActive) begin
            tbl_set = 1'b1;
          end else if (cmd_q == CmdPrecharge) begin
            if (addr_q[A10Bit]) tbl_clr_all = 1'b1;
            else                tbl_clr     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output content for the current state
  always_comb begin
    logic [1:0]  o_ba;
    logic [15:0] o_addr;
    logic [2:0]  o_cmd;
    o_ba     = '0;
    o_addr   = '0;
    o_cmd    = '0;
    out_user = '0;
    unique case (state_q)
      StPre: begin
        o_cmd = CmdPrecharge;
        if (is_all_bank(cmd_q)) o_addr[A10Bit] = 1'b1;
        else                    o_ba           = ba_q;
      end
      StAct: begin
        o_cmd                        = CmdActive;
        o_ba                         = ba_q;
        o_addr[ROW_ADDR_WIDTH-1:0]   = row_q;
      end
      StIssue: begin
        o_cmd  = cmd_q;
        o_ba   = ba_q;
        o_addr = addr_q;
        if (is_rw(cmd_q)) out_user = user_q;
      end
      default: ;
    endcase
    out_data                     = '0;
    out_data[OutBaLsb +: 2]      = o_ba;
    out_data[OutAddrLsb +: 16]   = o_addr;
    out_data[OutCmdLsb +: 3]     = o_cmd;
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    ba_d      = ba_q;
    row_d     = row_q;
    addr_d    = addr_q;
    user_d    = user_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    if (state_q == StIdle) begin
      if (s_axis_usr_cmd_valid) begin
        cmd_d  = s_cmd;
        ba_d   = s_ba;
        row_d  = s_row;
        addr_d = s_addr;
        user_d = s_axis_usr_cmd_user;
        case (s_cmd)
          CmdRd, CmdWt:                state_d = lk_hit ? StIssue : (lk_open ? StPre : StAct);
          CmdAutoRefresh, CmdLoadMode: state_d = any_open ? StPre : StIssue;
          // Redundant or disabled explicit commands are accepted and dropped
          CmdActive: begin
            if (!ExplPass || lk_hit) state_d = StIdle;
            else                     state_d = lk_open ? StPre : StIssue;
          end
          CmdPrecharge:                state_d = ExplPass ? StIssue : StIdle;
          default:                     state_d = StIssue;
        endcase
      end
    end else if (!m_valid_q) begin
      m_valid_d = 1'b1;
      m_data_d  = out_data;
      m_user_d  = out_user;
    end else if (m_axis_sdram_cmd_ready) begin
      m_valid_d = 1'b0;
      unique case (state_q)
        StPre:   state_d = is_rw(cmd_q) ? StAct : StIssue;
        StAct:   state_d = StIssue;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      ba_q      <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      user_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      user_q    <= user_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
    end
  end

  assign s_axis_usr_cmd_ready   = (state_q == StIdle);
  assign m_axis_sdram_cmd_valid = m_valid_q;
  assign m_axis_sdram_cmd_data  = m_data_q;
  assign m_axis_sdram_cmd_user  = m_user_q;

endmodule

// File: tb/tb_sdram_bank_row_agent.sv
// Bench for sdram_bank_row_agent: directed scenarios plus random commands,
// checked against a bank-table model that predicts the emitted command list.
module tb_sdram_bank_row_agent;

  localparam int unsigned RW = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] s_data = '0;
  logic [16:0] s_user = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [20:0] m_data;
  logic [16:0] m_user;
  logic        m_valid;
  logic        m_ready = 1'b0;

  logic [39:0] s2_data = '0;
  logic        s2_valid = 1'b0;
  logic        s2_ready;
  logic [20:0] m2_data;
  logic [16:0] m2_user;
  logic        m2_valid;

  always #5 clk = ~clk;

  sdram_bank_row_agent #(
    .ROW_ADDR_WIDTH   (RW),
    .EN_EXPL_CMD_PASS ("true")
  ) u_dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_usr_cmd_data    (s_data),
    .s_axis_usr_cmd_user    (s_user),
    .s_axis_usr_cmd_valid   (s_valid),
    .s_axis_usr_cmd_ready   (s_ready),
    .m_axis_sdram_cmd_data  (m_data),
    .m_axis_sdram_cmd_user  (m_user),
    .m_axis_sdram_cmd_valid (m_valid),
    .m_axis_sdram_cmd_ready (m_ready)
  );

  sdram_bank_row_agent #(
    .ROW_ADDR_WIDTH   (RW),
    .EN_EXPL_CMD_PASS ("false")
  ) u_dut_nopass (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_usr_cmd_data    (s2_data),
    .s_axis_usr_cmd_user    (17'h0),
    .s_axis_usr_cmd_valid   (s2_valid),
    .s_axis_usr_cmd_ready   (s2_ready),
    .m_axis_sdram_cmd_data  (m2_data),
    .m_axis_sdram_cmd_user  (m2_user),
    .m_axis_sdram_cmd_valid (m2_valid),
    .m_axis_sdram_cmd_ready (1'b1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int hold_first = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: which banks are open on which row, and the expected output list
  bit            mdl_open [4];
  logic [RW-1:0] mdl_row  [4];
  logic [37:0]   exp_q[$];  // {ba, A, cmd, user}

  function automatic logic [37:0] oc(input logic [1:0] ba, input logic [15:0] a,
                                     input logic [2:0] c, input logic [16:0] u);
    return {ba, a, c, u};
  endfunction

  function automatic logic [39:0] mk(input logic [2:0] c, input logic [1:0] ba,
                                     input logic [15:0] row, input logic [15:0] a);
    return {3'b000, ba, row, a, c};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mdl_open[i] = 1'b0;
      mdl_row[i]  = '0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_cmd(input logic [39:0] d, input logic [16:0] u);
    logic [2:0]    c;
    logic [1:0]    ba;
    logic [15:0]   a;
    logic [RW-1:0] r;
    bit            any;
    c   = d[2:0];
    a   = d[18:3];
    r   = d[19 +: RW];
    ba  = d[36:35];
    any = 1'b0;
    for (int i = 0; i < 4; i++) any |= mdl_open[i];
    case (c)
      3'd5, 3'd6: begin
        if (!(mdl_open[ba] && mdl_row[ba] == r)) begin
          if (mdl_open[ba]) exp_q.push_back(oc(ba, 16'h0000, 3'd4, 17'h0));
          exp_q.push_back(oc(ba, 16'(r), 3'd3, 17'h0));
          mdl_open[ba] = 1'b1;
          mdl_row[ba]  = r;
        end
        exp_q.push_back(oc(ba, a, c, u));
      end
      3'd0, 3'd1: begin
        if (any) exp_q.push_back(oc(2'd0, 16'h0400, 3'd4, 17'h0));
        for (int i = 0; i < 4; i++) mdl_open[i] = 1'b0;
        exp_q.push_back(oc(ba, a, c, 17'h0));
      end
      3'd3: begin
        if (!(mdl_open[ba] && mdl_row[ba] == r)) begin
          if (mdl_open[ba]) exp_q.push_back(oc(ba, 16'h0000, 3'd4, 17'h0));
          exp_q.push_back(oc(ba, a, 3'd3, 17'h0));
          mdl_open[ba] = 1'b1;
          mdl_row[ba]  = r;
        end
      end
      3'd4: begin
        exp_q.push_back(oc(ba, a, 3'd4, 17'h0));
        if (a[10]) for (int i = 0; i < 4; i++) mdl_open[i] = 1'b0;
        else       mdl_open[ba] = 1'b0;
      end
      default: exp_q.push_back(oc(ba, a, c, 17'h0));
    endcase
  endfunction

  // Send one command and collect everything the DUT emits until it is idle again
  task automatic run_cmd(input logic [39:0] d, input logic [16:0] u, input string tag);
    int          n;
    int          got;
    int          exp_n;
    int          held;
    logic        prev_v, prev_r, hs_prev;
    logic [37:0] prev_o, cur, e;
    got = 0; held = 0; prev_v = 1'b0; prev_r = 1'b0; hs_prev = 1'b0; prev_o = '0;
    model_cmd(d, u);
    exp_n = exp_q.size();
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " s_ready before accept"}, s_ready, 1'b1);
    s_data  = d;
    s_user  = u;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    for (n = 0; n < 80; n++) begin
      cur = {m_data, m_user};
      if (prev_v && !prev_r) begin
        check_eq({tag, " held valid"}, m_valid, 1'b1);
        check_eq({tag, " held data"}, cur, prev_o);
      end
      if (hs_prev) check_eq({tag, " valid gap"}, m_valid, 1'b0);
      if (m_valid) check_eq({tag, " s_ready while busy"}, s_ready, 1'b0);
      if (s_ready) break;
      if (m_valid && held < hold_first) m_ready = 1'b0;
      else                              m_ready = ($urandom_range(99) < 70);
      if (m_valid && !m_ready) held++;
      hs_prev = m_valid && m_ready;
      if (hs_prev) begin
        got++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq($sformatf("%s out#%0d", tag, got), cur, e);
        end
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_o = cur;
      @(negedge clk);
    end
    check_eq({tag, " back to idle"}, s_ready, 1'b1);
    check_eq({tag, " idle valid"}, m_valid, 1'b0);
    check_eq({tag, " cmd count"}, got, exp_n);
    exp_q.delete();
  endtask

  initial begin
    int          n;
    logic [2:0]  c;
    logic [15:0] row, a;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset m_valid", m_valid, 1'b0);
    check_eq("reset m_data", m_data, 21'h0);
    check_eq("reset m_user", m_user, 17'h0);
    check_eq("reset s_ready", s_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post-reset s_ready", s_ready, 1'b1);

    run_cmd(mk(3'd6, 2'd1, 16'h0123, 16'h0040), 17'h00007, "rd closed");
    run_cmd(mk(3'd6, 2'd1, 16'h0123, 16'h0040), 17'h00007, "rd hit");
    run_cmd(mk(3'd5, 2'd1, 16'h0200, 16'h0008), 17'h1000f, "wt miss");
    run_cmd(mk(3'd6, 2'd0, 16'h0011, 16'h0010), 17'h00003, "rd b0");
    run_cmd(mk(3'd6, 2'd2, 16'h0022, 16'h0020), 17'h00001, "rd b2");
    run_cmd(mk(3'd1, 2'd0, 16'h0000, 16'h0000), 17'h0, "refresh open");
    run_cmd(mk(3'd6, 2'd0, 16'h0011, 16'h0010), 17'h00003, "rd after refresh");
    hold_first = 5;
    run_cmd(mk(3'd6, 2'd3, 16'h0033, 16'h0030), 17'h00002, "act stall");
    hold_first = 0;
    run_cmd(mk(3'd4, 2'd3, 16'h0000, 16'h0000), 17'h0, "pre b3");
    run_cmd(mk(3'd3, 2'd3, 16'h0005, 16'h0005), 17'h0, "active 1");
    run_cmd(mk(3'd3, 2'd3, 16'h0005, 16'h0005), 17'h0, "active dup");
    run_cmd(mk(3'd4, 2'd0, 16'h0000, 16'h0400), 17'h0, "pre all");
    run_cmd(mk(3'd0, 2'd0, 16'h0000, 16'h0230), 17'h0, "load mode idle");
    run_cmd(mk(3'd6, 2'd2, 16'h1fff, 16'h0001), 17'h0, "rd row max");
    run_cmd(mk(3'd6, 2'd2, 16'hffff, 16'h0002), 17'h0, "rd upper bits ignored");
    run_cmd(mk(3'd2, 2'd2, 16'h0000, 16'h0000), 17'h0, "stop burst");
    run_cmd(mk(3'd7, 2'd1, 16'h0000, 16'h0000), 17'h0, "nop");

    // Reset while a PRE is being presented
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    m_ready = 1'b0;
    s_data  = mk(3'd6, 2'd2, 16'h0100, 16'h0004);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("pre before reset", {m_valid, m_data}, {1'b1, 2'd2, 16'h0000, 3'd4});
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort m_valid", m_valid, 1'b0);
    check_eq("abort s_ready", s_ready, 1'b1);
    check_eq("abort m_data", m_data, 21'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(mk(3'd6, 2'd2, 16'h0100, 16'h0004), 17'h00055, "rd after abort");

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(15) < 10) c = ($urandom_range(1) != 0) ? 3'd6 : 3'd5;
      else                         c = 3'($urandom_range(7));
      row = 16'($urandom_range(3) * 16'h10) | 16'($urandom_range(7) << 13);
      a   = 16'($urandom);
      s_data = mk(c, 2'($urandom_range(3)), row, a);
      s_data[39:37] = 3'($urandom_range(7));
      run_cmd(s_data, 17'($urandom), $sformatf("rand%0d", k));
    end

    // Pass-through disabled: explicit ACTIVE/PRECHARGE are swallowed
    for (int k = 0; k < 3; k++) begin
      s2_data = (k == 2) ? mk(3'd4, 2'd3, 16'h0000, 16'h0000) : mk(3'd3, 2'd3, 16'h0005, 16'h0005);
      n = 0;
      while (!s2_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("nopass s_ready", s2_ready, 1'b1);
      s2_valid = 1'b1;
      @(negedge clk);
      s2_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        check_eq($sformatf("nopass cmd%0d valid", k), m2_valid, 1'b0);
        @(negedge clk);
      end
      check_eq("nopass idle", s2_ready, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_bank_row_agent.md
Name: sdram_bank_row_agent

Overview:
- Sits directly downstream of the AXI-SDRAM slave interface's user-command stream and upstream of the SDRAM command engine.
- Keeps a per-bank open-row table for 4 banks.
- Expands each RD/WT request into the minimal PRECHARGE/ACTIVE/RD-or-WT sequence.
- Precharges all banks before AUTO_REFRESH and LOAD_MODE.
- Frees the upstream AXI interface from any bank/row state tracking.

Parameters:
- ROW_ADDR_WIDTH, 13, number of row-address bits compared and forwarded (valid range 11..16).
- EN_EXPL_CMD_PASS, "true", "true": upstream ACTIVE/PRECHARGE commands are forwarded and update the table. "false": they are dropped (accepted, not forwarded).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_usr_cmd_data  in  40  {rsv(3), ba(2), row(16), A15-0(16), cmd(3)}
- s_axis_usr_cmd_user  in  17  {auto stop-burst(1), burst len-1(16)}
- s_axis_usr_cmd_valid  in  1  upstream valid
- s_axis_usr_cmd_ready  out  1  upstream ready
- m_axis_sdram_cmd_data  out  21  {ba(2), A15-0(16), cmd(3)}
- m_axis_sdram_cmd_user  out  17  copy of the latched user field (meaningful on RD/WT only, 0 otherwise)
- m_axis_sdram_cmd_valid  out  1  downstream valid
- m_axis_sdram_cmd_ready  in  1  downstream ready

Behaviour:
- Command codes are fixed in the shared package:
  - 0 LOAD_MODE, 1 AUTO_REFRESH, 2 STOP_BURST, 3 ACTIVE, 4 PRECHARGE, 5 WT, 6 RD, 7 NOP.
  - PRECHARGE-all is A10=1; single-bank PRECHARGE is A10=0.
- Table: per bank an open flag (reset 0) and a row register of ROW_ADDR_WIDTH bits (reset 0). Row comparison uses row[ROW_ADDR_WIDTH-1:0].
- FSM states: IDLE, PRE, ACT, ISSUE.
  - s_axis_usr_cmd_ready = (state==IDLE). It is 1 from reset onward.
  - On an IDLE handshake, latch data/user and select the next state from the table (1-cycle decision, registered outputs).
- RD/WT to bank b, row r:
  - Bank open, same row -> ISSUE.
  - Bank open, different row -> PRE (ba=b, A10=0) -> ACT (ba=b, A=r) -> ISSUE.
  - Bank closed -> ACT -> ISSUE.
  - ISSUE forwards ba, A15-0 (column), cmd and user unchanged.
- AUTO_REFRESH / LOAD_MODE:
  - Any bank open -> PRE (A10=1, ba=0) -> ISSUE.
  - No bank open -> ISSUE.
  - All open flags are cleared on the PRE handshake.
- ACTIVE from upstream (EN_EXPL_CMD_PASS="true"):
  - If the bank is already open with a different row, emit PRE first.
  - If it is already open with the same row, the command is accepted and dropped (no output).
  - Otherwise ISSUE; set flag and row on the handshake.
- PRECHARGE from upstream:
  - ISSUE it.
  - On the handshake clear bank ba's flag, or all flags if A10=1.
- STOP_BURST, NOP, reserved: ISSUE unchanged, table untouched.
- Output stage rules:
  - Each non-IDLE state asserts m_valid with stable data until m_ready.
  - The state advances only on the handshake.
  - After the ISSUE handshake return to IDLE. m_valid drops for at least one cycle between commands.
  - Throughput is at most 1 command per 2 cycles.
- Table updates:
  - Table updates occur on the handshake of the emitted PRE/ACT/ISSUE, never at accept time.
  - ACT handshake: flag[b]=1, row[b]=r.
- Reset values: m_valid=0, m_data=0, m_user=0, state=IDLE, table cleared.
- Reset asserted mid-sequence aborts immediately: partial sequences are discarded and no command is replayed.
- Dropped commands (EN_EXPL_CMD_PASS="false", or redundant ACTIVE) complete in IDLE→IDLE with no m_valid.

Decomposition:
- Package sdram_cmd_pkg:
  - command code constants.
  - bank count (4).
  - field bit-offsets of the 40-bit user command and the 21-bit output command.
- One sub-module sdram_open_row_table:
  - 4 flag/row registers.
  - hit/miss/any-open lookup outputs.
  - set/clear/clear-all update ports.
- The FSM and output register stay in the top.

Test Plan:
- After reset, RD ba=1 row=0x0123 col=0x0040 user=0x00007 -> outputs ACTIVE{ba1,A=0x0123}, then RD{ba1,A=0x0040,user=0x00007}; table bank1 open/0x0123.
- Repeat RD ba=1 row=0x0123 -> single RD output, no PRE/ACT; then WT ba=1 row=0x0200 -> PRE{ba1,A10=0}, ACT{ba1,A=0x0200}, WT.
- Banks 0 and 2 open, then AUTO_REFRESH -> PRE{A=0x0400}, then AUTO_REFRESH. A following RD to bank 0 must emit ACT first.
- Hold m_ready=0 for 5 cycles during ACT -> data stable, s_ready=0, no table change until the handshake.
- Upstream ACTIVE ba=3 row=5 twice with EN_EXPL_CMD_PASS="true" -> one ACTIVE output, second dropped. With "false" -> no output for either.
- Assert rst_n=0 while in PRE, release -> m_valid=0, table empty, s_ready=1; the next RD emits ACT, not PRE.
